axi_lite_rr_arbiter: RTL and testbench



---
 rtl/axi_lite_rr_arbiter.sv | 150 +++++++++++++++
 tb/tb_axi_lite_rr_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_rr_arbiter.sv
// Round-robin arbiter and transaction sequencer for a shared AXI4-Lite datapath.
// It grants one master at a time, decodes the target slave and holds the grant until the response handshake or a timeout.
module axi_lite_rr_arbiter #(
    parameter int NUM_MASTER = 2,
    parameter int NUM_SLAVE = 2,
    parameter int ADDR_W = 32,
    parameter logic [ADDR_W-1:0] LOW_ADDR_TABLE [NUM_SLAVE] = '{32'h0, 32'h10},
    parameter logic [ADDR_W-1:0] HIGH_ADDR_TABLE [NUM_SLAVE] = '{32'h10, 32'h20},
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                                              aclk,
    input  logic                                              areset,
    input  logic [NUM_MASTER-1:0]                             arvalid,
    input  logic [NUM_MASTER-1:0]                             awvalid,
    input  logic [NUM_MASTER*ADDR_W-1:0]                      araddr,
    input  logic [NUM_MASTER*ADDR_W-1:0]                      awaddr,
    input  logic                                              r_hs,
    input  logic                                              b_hs,
    output logic [NUM_MASTER-1:0]                             grant,
    output logic [$clog2(NUM_MASTER)-1:0]                     sel_m,
    output logic [(NUM_SLAVE > 1 ? $clog2(NUM_SLAVE) : 1)-1:0] sel_s,
    output logic                                              rd_active,
    output logic                                              wr_active,
    output logic                                              dec_err,
    output logic                                              timeout
);

    localparam int MW = $clog2(NUM_MASTER);
    localparam int SW = (NUM_SLAVE > 1) ? $clog2(NUM_SLAVE) : 1;
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [NUM_MASTER-1:0] GRANT_ONE = 1;

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    state_t                state;
    state_t                state_next;
    logic [MW-1:0]         last;
    logic [NUM_MASTER-1:0] prev_write;
    logic [CW-1:0]         count;

    int                    cand;
    logic                  win_found;
    logic [MW-1:0]         win_idx;
    logic                  win_write;
    logic [ADDR_W-1:0]     win_addr;
    logic [SW-1:0]         dec_idx;
    logic                  dec_miss;
    logic                  at_limit;
    logic                  timeout_next;

    // First requester scanning upward from the master after the last winner.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int off = 1; off <= NUM_MASTER; off++) begin
            cand = (int'(last) + off) % NUM_MASTER;
            if (!win_found && (arvalid[cand] || awvalid[cand])) begin
                win_found = 1'b1;
                win_idx   = MW'(cand);
            end
        end
    end

    // A master asking for both directions alternates, starting with a read.
    always_comb begin
        win_write = awvalid[win_idx] && (!arvalid[win_idx] || !prev_write[win_idx]);
        win_addr  = win_write ? awaddr[int'(win_idx)*ADDR_W +: ADDR_W]
                              : araddr[int'(win_idx)*ADDR_W +: ADDR_W];
        dec_idx   = '0;
        dec_miss  = 1'b1;
        for (int s = NUM_SLAVE - 1; s >= 0; s--) begin
            if (win_addr >= LOW_ADDR_TABLE[s] && win_addr < HIGH_ADDR_TABLE[s]) begin
                dec_idx  = SW'(s);
                dec_miss = 1'b0;
            end
        end
    end

    assign at_limit = (count == CW'(TIMEOUT_CYCLES - 1));

    // A handshake in the limit cycle wins over the timeout.
    always_comb begin
        state_next   = state;
        timeout_next = 1'b0;
        case (state)
            IDLE: begin
                if (win_found) begin
                    state_next = win_write ? WRITE : READ;
                end
            end
            READ: begin
                if (r_hs) begin
                    state_next = IDLE;
                end else if (at_limit) begin
                    state_next   = IDLE;
                    timeout_next = 1'b1;
                end
            end
            WRITE: begin
                if (b_hs) begin
                    state_next = IDLE;
                end else if (at_limit) begin
                    state_next   = IDLE;
                    timeout_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state      <= IDLE;
            grant      <= '0;
            sel_m      <= '0;
            sel_s      <= '0;
            rd_active  <= 1'b0;
            wr_active  <= 1'b0;
            dec_err    <= 1'b0;
            timeout    <= 1'b0;
            last       <= MW'(NUM_MASTER - 1);
            prev_write <= '1;
            count      <= '0;
        end else begin
            state     <= state_next;
            timeout   <= timeout_next;
            rd_active <= (state_next == READ);
            wr_active <= (state_next == WRITE);
            if (state == IDLE) begin
                if (win_found) begin
                    grant               <= GRANT_ONE << win_idx;
                    sel_m               <= win_idx;
                    sel_s               <= dec_idx;
                    dec_err             <= dec_miss;
                    last                <= win_idx;
                    prev_write[win_idx] <= win_write;
                end
                count <= '0;
            end else if (state_next == IDLE) begin
                grant   <= '0;
                dec_err <= 1'b0;
                count   <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_rr_arbiter.sv
// Bench for axi_lite_rr_arbiter: directed vector table, hand-written timeout/reset sequences,
// then random traffic checked against a transaction-level reference model.
module tb_axi_lite_rr_arbiter;

    localparam int NM = 2;
    localparam int NS = 2;
    localparam int AW = 32;
    localparam int TO = 8;
    localparam logic [AW-1:0] LO [NS] = '{32'h0, 32'h10};
    localparam logic [AW-1:0] HI [NS] = '{32'h10, 32'h20};

    logic aclk = 1'b0;
    always #5 aclk = ~aclk;

    logic             areset;
    logic [NM-1:0]    arvalid, awvalid;
    logic [NM*AW-1:0] araddr, awaddr;
    logic             r_hs, b_hs;
    logic [NM-1:0]    grant;
    logic             sel_m, sel_s, rd_active, wr_active, dec_err, timeout;

    int errors = 0;
    int checks = 0;

    axi_lite_rr_arbiter #(
        .NUM_MASTER(NM), .NUM_SLAVE(NS), .ADDR_W(AW),
        .LOW_ADDR_TABLE(LO), .HIGH_ADDR_TABLE(HI), .TIMEOUT_CYCLES(TO)
    ) dut (
        .aclk(aclk), .areset(areset),
        .arvalid(arvalid), .awvalid(awvalid), .araddr(araddr), .awaddr(awaddr),
        .r_hs(r_hs), .b_hs(b_hs),
        .grant(grant), .sel_m(sel_m), .sel_s(sel_s),
        .rd_active(rd_active), .wr_active(wr_active),
        .dec_err(dec_err), .timeout(timeout)
    );

    typedef struct {
        logic [1:0]  ar, aw;
        logic [31:0] ra0, ra1, wa0, wa1;
        logic        rh, bh;
        logic [1:0]  eg;
        logic        erd, ewr, ess, edec, eto;
    } vec_t;

    vec_t vecs[$];

    task automatic addVec(input logic [1:0] ar, aw, input logic [31:0] ra0, ra1, wa0, wa1,
                          input logic rh, bh, input logic [1:0] eg,
                          input logic erd, ewr, ess, edec, eto);
        vec_t v;
        v.ar = ar;  v.aw = aw;  v.ra0 = ra0; v.ra1 = ra1; v.wa0 = wa0; v.wa1 = wa1;
        v.rh = rh;  v.bh = bh;  v.eg = eg;   v.erd = erd; v.ewr = ewr;
        v.ess = ess; v.edec = edec; v.eto = eto;
        vecs.push_back(v);
    endtask

    // Inputs are held across the next rising edge; outputs are sampled 1 time unit after it.
    task automatic applyStimulus(input logic rst, input logic [1:0] ar, aw,
                                 input logic [31:0] ra0, ra1, wa0, wa1, input logic rh, bh);
        areset  = rst;
        arvalid = ar;
        awvalid = aw;
        araddr  = {ra1, ra0};
        awaddr  = {wa1, wa0};
        r_hs    = rh;
        b_hs    = bh;
        @(posedge aclk);
        #1;
    endtask

    task automatic compareField(input string tag, input string field,
                                input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s.%s: got %0h, expected %0h", tag, field, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [1:0] eg, input logic erd, ewr,
                               input logic esm, ess, edec, eto, input bit sel_valid);
        compareField(tag, "grant",     32'(grant),     32'(eg));
        compareField(tag, "rd_active", 32'(rd_active), 32'(erd));
        compareField(tag, "wr_active", 32'(wr_active), 32'(ewr));
        compareField(tag, "dec_err",   32'(dec_err),   32'(edec));
        compareField(tag, "timeout",   32'(timeout),   32'(eto));
        if (sel_valid) begin
            compareField(tag, "sel_m", 32'(sel_m), 32'(esm));
            compareField(tag, "sel_s", 32'(sel_s), 32'(ess));
        end
    endtask

    // Reference model: one open transaction at a time, age counts granted cycles from 1.
    bit       m_busy, m_read, m_dec, m_to;
    int       m_master, m_slave, m_age, m_last;
    bit [1:0] m_prevw;

    task automatic modelReset();
        m_busy = 0; m_read = 0; m_dec = 0; m_to = 0;
        m_master = 0; m_slave = 0; m_age = 0; m_last = NM - 1;
        m_prevw = 2'b11;
    endtask

    function automatic void decodeAddr(input logic [31:0] a, output int s, output bit err);
        err = 1;
        s   = 0;
        for (int k = 0; k < NS; k++) begin
            if (a >= LO[k] && a < HI[k]) begin
                s   = k;
                err = 0;
                break;
            end
        end
    endfunction

    task automatic modelStep(input logic [1:0] ar, aw, input logic [63:0] ra, wa, input logic rh, bh);
        int          i;
        logic [31:0] a;
        m_to = 0;
        if (m_busy) begin
            if (m_read ? rh : bh) begin
                m_busy = 0;
            end else if (m_age == TO) begin
                m_busy = 0;
                m_to   = 1;
            end else begin
                m_age++;
            end
        end else begin
            for (int k = 1; k <= NM; k++) begin
                i = (m_last + k) % NM;
                if (ar[i] || aw[i]) begin
                    m_busy   = 1;
                    m_master = i;
                    m_last   = i;
                    m_age    = 1;
                    if (ar[i] && aw[i]) m_read = m_prevw[i];
                    else                m_read = ar[i];
                    m_prevw[i] = !m_read;
                    a = m_read ? ra[i*AW +: AW] : wa[i*AW +: AW];
                    decodeAddr(a, m_slave, m_dec);
                    break;
                end
            end
        end
    endtask

    initial begin
        logic        rst, rh, bh;
        logic [1:0]  ar, aw;
        logic [31:0] ra0, ra1, wa0, wa1;

        // Directed cycle-by-cycle vectors, starting from reset (last = 1, toggles = write).
        addVec(2'b01, 2'b00, 32'h04, 0, 0, 0,       0, 0, 2'b01, 1, 0, 0, 0, 0);
        addVec(2'b00, 2'b00, 32'h04, 0, 0, 0,       0, 0, 2'b01, 1, 0, 0, 0, 0);
        addVec(2'b00, 2'b00, 32'h04, 0, 0, 0,       1, 0, 2'b00, 0, 0, 0, 0, 0);
        addVec(2'b00, 2'b11, 0, 0, 32'h08, 32'h14,  0, 0, 2'b10, 0, 1, 1, 0, 0);
        addVec(2'b00, 2'b11, 0, 0, 32'h08, 32'h14,  1, 0, 2'b10, 0, 1, 1, 0, 0);
        addVec(2'b00, 2'b11, 0, 0, 32'h08, 32'h14,  0, 1, 2'b00, 0, 0, 0, 0, 0);
        addVec(2'b00, 2'b11, 0, 0, 32'h08, 32'h14,  0, 0, 2'b01, 0, 1, 0, 0, 0);
        addVec(2'b00, 2'b11, 0, 0, 32'h08, 32'h14,  0, 1, 2'b00, 0, 0, 0, 0, 0);
        addVec(2'b00, 2'b11, 0, 0, 32'h08, 32'h14,  0, 0, 2'b10, 0, 1, 1, 0, 0);
        addVec(2'b00, 2'b11, 0, 0, 32'h08, 32'h14,  0, 1, 2'b00, 0, 0, 0, 0, 0);
        addVec(2'b10, 2'b10, 0, 32'h18, 0, 32'h18,  0, 0, 2'b10, 1, 0, 1, 0, 0);
        addVec(2'b10, 2'b10, 0, 32'h18, 0, 32'h18,  1, 0, 2'b00, 0, 0, 0, 0, 0);
        addVec(2'b10, 2'b10, 0, 32'h18, 0, 32'h18,  0, 0, 2'b10, 0, 1, 1, 0, 0);
        addVec(2'b10, 2'b10, 0, 32'h18, 0, 32'h18,  0, 1, 2'b00, 0, 0, 0, 0, 0);
        addVec(2'b10, 2'b10, 0, 32'h18, 0, 32'h18,  0, 0, 2'b10, 1, 0, 1, 0, 0);
        addVec(2'b10, 2'b10, 0, 32'h18, 0, 32'h18,  1, 0, 2'b00, 0, 0, 0, 0, 0);
        addVec(2'b00, 2'b00, 0, 0, 0, 0,            1, 1, 2'b00, 0, 0, 0, 0, 0);
        addVec(2'b01, 2'b00, 32'h40, 0, 0, 0,       0, 0, 2'b01, 1, 0, 0, 1, 0);
        addVec(2'b00, 2'b00, 32'h40, 0, 0, 0,       0, 0, 2'b01, 1, 0, 0, 1, 0);
        addVec(2'b00, 2'b00, 32'h40, 0, 0, 0,       1, 0, 2'b00, 0, 0, 0, 0, 0);
        addVec(2'b01, 2'b00, 32'h10, 0, 0, 0,       0, 0, 2'b01, 1, 0, 1, 0, 0);
        addVec(2'b00, 2'b00, 0, 0, 0, 0,            1, 0, 2'b00, 0, 0, 0, 0, 0);
        addVec(2'b00, 2'b10, 0, 0, 0, 32'h20,       0, 0, 2'b10, 0, 1, 0, 1, 0);
        addVec(2'b00, 2'b00, 0, 0, 0, 0,            0, 1, 2'b00, 0, 0, 0, 0, 0);
        addVec(2'b00, 2'b01, 0, 0, 32'h0f, 0,       0, 0, 2'b01, 0, 1, 0, 0, 0);
        addVec(2'b00, 2'b00, 0, 0, 0, 0,            0, 1, 2'b00, 0, 0, 0, 0, 0);

        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("reset", 2'b00, 0, 0, 0, 0, 0, 0, 1);

        foreach (vecs[i]) begin
            applyStimulus(0, vecs[i].ar, vecs[i].aw, vecs[i].ra0, vecs[i].ra1,
                          vecs[i].wa0, vecs[i].wa1, vecs[i].rh, vecs[i].bh);
            checkOutput($sformatf("vec%0d", i), vecs[i].eg, vecs[i].erd, vecs[i].ewr,
                        vecs[i].eg == 2'b10, vecs[i].ess, vecs[i].edec, vecs[i].eto, vecs[i].eg != 2'b00);
        end

        // Read with no handshake: grant open for TO cycles, then a single timeout pulse.
        applyStimulus(0, 2'b01, 0, 32'h04, 0, 0, 0, 0, 0);
        checkOutput("to_grant", 2'b01, 1, 0, 0, 0, 0, 0, 1);
        for (int k = 1; k < TO; k++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
            checkOutput($sformatf("to_hold%0d", k), 2'b01, 1, 0, 0, 0, 0, 0, 1);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("to_pulse", 2'b00, 0, 0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("to_after", 2'b00, 0, 0, 0, 0, 0, 0, 0);

        // Handshake in the limit cycle completes normally.
        applyStimulus(0, 2'b01, 0, 32'h04, 0, 0, 0, 0, 0);
        checkOutput("hs_grant", 2'b01, 1, 0, 0, 0, 0, 0, 1);
        for (int k = 1; k < TO; k++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
            checkOutput($sformatf("hs_hold%0d", k), 2'b01, 1, 0, 0, 0, 0, 0, 1);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
        checkOutput("hs_last", 2'b00, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("hs_after", 2'b00, 0, 0, 0, 0, 0, 0, 0);

        // Write whose only responses are r_hs: those are ignored and it times out.
        applyStimulus(0, 0, 2'b01, 0, 0, 32'h14, 0, 0, 0);
        checkOutput("wto_grant", 2'b01, 0, 1, 0, 1, 0, 0, 1);
        for (int k = 1; k < TO; k++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
            checkOutput($sformatf("wto_hold%0d", k), 2'b01, 0, 1, 0, 1, 0, 0, 1);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
        checkOutput("wto_pulse", 2'b00, 0, 0, 0, 0, 0, 1, 0);

        // Reset in the middle of a write; afterwards master 0 has priority again.
        applyStimulus(0, 0, 2'b01, 0, 0, 32'h14, 0, 0, 0);
        checkOutput("rst_grant", 2'b01, 0, 1, 0, 1, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("rst_hold", 2'b01, 0, 1, 0, 1, 0, 0, 1);
        applyStimulus(1, 0, 2'b01, 0, 0, 32'h14, 0, 0, 0);
        checkOutput("rst_mid", 2'b00, 0, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 2'b11, 0, 0, 32'h14, 32'h08, 0, 0);
        checkOutput("rst_next", 2'b01, 0, 1, 0, 1, 0, 0, 1);

        // Random traffic against the reference model.
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        modelReset();
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            ar  = 2'($urandom_range(0, 3));
            aw  = 2'($urandom_range(0, 3));
            ra0 = $urandom_range(0, 'h2f);
            ra1 = $urandom_range(0, 'h2f);
            wa0 = $urandom_range(0, 'h2f);
            wa1 = $urandom_range(0, 'h2f);
            rh  = ($urandom_range(0, 5) == 0);
            bh  = ($urandom_range(0, 5) == 0);
            if (rst) modelReset();
            else     modelStep(ar, aw, {ra1, ra0}, {wa1, wa0}, rh, bh);
            applyStimulus(rst, ar, aw, ra0, ra1, wa0, wa1, rh, bh);
            checkOutput($sformatf("rand%0d", c), m_busy ? 2'(1 << m_master) : 2'b00,
                        m_busy && m_read, m_busy && !m_read, 1'(m_master), 1'(m_slave),
                        m_busy && m_dec, m_to, m_busy);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
